instr_fetch_unit: RTL and testbench

- Produces the 32-bit instruction word (IWord) and its PC for the decode/control stage, so it is the upstream end of the IWord interface.
- Owns the PC register and issues word reads to instruction memory, one outstanding request at a time.
- Holds each fetched word until decode accepts it.
- Applies PC redirects (branch/jump, PCSelect) from the execute stage and discards fetches that are already in flight when a redirect arrives.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem read in flight and holds the word for decode.
// Optional IFU_PERF_CNT_EN adds fetch_count/flush_count event counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] iword,
  output logic [31:0] iword_pc,
  output logic        iword_valid,
  input  logic        iword_ready,
  input  logic        PCSelect,
  input  logic [31:0] branch_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] iword_reg;
  logic [31:0] iword_pc_reg;
  logic        kill_reg;
  logic [31:0] redirect_pc;

  // Low target bits are meaningless for word fetches and are simply masked off.
  assign redirect_pc = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_REQ;
      pc_reg       <= RESET_PC;
      kill_reg     <= 1'b0;
      iword_reg    <= NOP_WORD;
      iword_pc_reg <= RESET_PC;
    end else if (PCSelect) begin
      pc_reg <= redirect_pc;
      case (state_reg)
        S_REQ: begin
          // An accepted request still carries the old PC, so its response is stale.
          if (imem_req_ready) begin
            state_reg <= S_WAIT;
            kill_reg  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            kill_reg  <= 1'b0;
            state_reg <= S_REQ;
          end else begin
            kill_reg <= 1'b1;
          end
        end
        S_HOLD: begin
          iword_reg <= NOP_WORD;
          state_reg <= S_REQ;
        end
        default: state_reg <= S_REQ;
      endcase
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem_req_ready) state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_reg) begin
              kill_reg  <= 1'b0;
              state_reg <= S_REQ;
            end else begin
              iword_reg    <= imem_resp_data;
              iword_pc_reg <= pc_reg;
              state_reg    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (iword_ready) begin
            pc_reg    <= pc_reg + 32'd4;
            iword_reg <= NOP_WORD;
            state_reg <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

  // Handshake outputs follow the state; reset masks them so nothing is offered mid-reset.
  assign imem_req_valid = (state_reg == S_REQ) && !rst;
  assign iword_valid    = (state_reg == S_HOLD) && !rst;
  assign imem_addr      = pc_reg;
  assign iword          = iword_reg;
  assign iword_pc       = iword_pc_reg;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg <= 32'd0;
      flush_count_reg <= 32'd0;
    end else begin
      if (iword_valid && iword_ready) fetch_count_reg <= fetch_count_reg + 32'd1;
      if (PCSelect) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: architectural-PC scoreboard checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        iword_ready = 1'b0;
  logic        PCSelect = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] iword;
  logic [31:0] iword_pc;
  logic        iword_valid;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .iword(iword), .iword_pc(iword_pc), .iword_valid(iword_valid), .iword_ready(iword_ready),
    .PCSelect(PCSelect), .branch_target(branch_target)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  initial forever #5 clk = ~clk;

  // Stimulus knobs applied at each falling edge.
  bit          drv_rst = 1'b1, drv_ready = 1'b0, drv_psel = 1'b0, mem_ready_on = 1'b1;
  logic [31:0] drv_bt = 32'd0;
  int          mem_lat = 1;

  // Memory bookkeeping and architectural model.
  bit          model_on = 1'b0, exp_valid = 1'b0, stale = 1'b0, mem_out = 1'b0;
  logic [31:0] exp_pc = 32'd0, mem_addr = 32'd0, exp_fetch = 32'd0, exp_flush = 32'd0;
  int          mem_cnt = 0;
  logic [31:0] acc_q[$], del_pc_q[$], del_data_q[$];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h00A0_0093;
    return a ^ 32'hA500_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst            = drv_rst;
    iword_ready    = drv_ready;
    PCSelect       = drv_psel;
    branch_target  = drv_bt;
    imem_req_ready = mem_ready_on;
    if (mem_out && mem_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_fn(mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #3;
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      seen = iword_valid;
    end
    chk({name, "_wait"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    drv_rst  = 1'b1;
    drv_psel = 1'b0;
    step();
    step();
    drv_rst = 1'b0;
    acc_q.delete();
    del_pc_q.delete();
    del_data_q.delete();
  endtask

  // Compare process: the PC the fetch unit must be working on follows only consumes and redirects.
  initial forever begin
    bit hs, resp_now, consumed, next_valid;
    @(negedge clk);
    #2;
    if (rst) begin
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      model_on = 1'b1; exp_pc = RESET_PC; exp_valid = 1'b0; stale = 1'b0;
      mem_out = 1'b0; mem_cnt = 0; exp_fetch = 32'd0; exp_flush = 32'd0;
    end else if (model_on) begin
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, !mem_out && !exp_valid});
      chk("imem_addr", imem_addr, exp_pc);
      chk("iword_valid", {31'd0, iword_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("iword_pc", iword_pc, exp_pc);
        chk("iword", iword, mem_fn(exp_pc));
      end else begin
        chk("iword_nop", iword, NOP_WORD);
      end
`ifdef IFU_PERF_CNT_EN
      chk("fetch_count", fetch_count, exp_fetch);
      chk("flush_count", flush_count, exp_flush);
`endif
      hs       = imem_req_valid && imem_req_ready;
      resp_now = imem_resp_valid && mem_out;
      consumed = exp_valid && iword_ready;
      if (consumed) begin
        del_pc_q.push_back(iword_pc);
        del_data_q.push_back(iword);
        $display("consume pc=%h iword=%h", iword_pc, iword);
      end
      next_valid = (resp_now && !stale && !PCSelect) || (exp_valid && !iword_ready && !PCSelect);
      exp_fetch = exp_fetch + {31'd0, consumed};
      exp_flush = exp_flush + {31'd0, PCSelect};
      if (PCSelect) exp_pc = branch_target & 32'hFFFF_FFFC;
      else if (consumed) exp_pc = exp_pc + 32'd4;
      if (resp_now) begin
        stale   = 1'b0;
        mem_out = 1'b0;
      end
      if (hs) begin
        stale   = PCSelect;
        acc_q.push_back(imem_addr);
        mem_out = 1'b1;
        mem_addr = imem_addr;
        mem_cnt = mem_lat - 1;
      end else begin
        if (mem_out && PCSelect) stale = 1'b1;
        if (mem_out && mem_cnt > 0) mem_cnt--;
      end
      exp_valid = next_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t1_addr[4];
    logic [31:0] t1_data[4];
    int n;
    t1_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    t1_data = '{32'hA500_0013, 32'hA500_0017, 32'hA500_001B, 32'hA500_001F};

    // Reset values.
    step();
    step();
    chk("reset_iword_valid", {31'd0, iword_valid}, 32'd0);
    chk("reset_iword", iword, 32'h0000_0013);
    chk("reset_iword_pc", iword_pc, 32'h0000_0000);
    chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Sequential fetch, single-cycle memory, decode always ready.
    drv_rst = 1'b0; drv_ready = 1'b1; mem_ready_on = 1'b1; mem_lat = 1;
    acc_q.delete(); del_pc_q.delete(); del_data_q.delete();
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
      end
    end while (del_pc_q.size() < 4 && n < 40);
    chk("t1_cycles", n, 32'd12);
    chk("t1_acc_n", acc_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < acc_q.size() && i < del_pc_q.size(); i++) begin
      chk("t1_addr", acc_q[i], t1_addr[i]);
      chk("t1_pc", del_pc_q[i], t1_addr[i]);
      chk("t1_data", del_data_q[i], t1_data[i]);
    end

    // Decode stall on a held word, then redirect while holding with ready high.
    drv_ready = 1'b0;
    do_reset();
    mem_ready_on = 1'b0; drv_psel = 1'b1; drv_bt = 32'h40;
    step();
    drv_psel = 1'b0; mem_ready_on = 1'b1;
    wait_valid("t2", 20);
    chk("t2_iword", iword, 32'h00A0_0093);
    chk("t2_pc", iword_pc, 32'h40);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_stall_iword", iword, 32'h00A0_0093);
      chk("t2_stall_pc", iword_pc, 32'h40);
      chk("t2_stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;
    step();
    chk("t2_next_req", {31'd0, imem_req_valid}, 32'd1);
    chk("t2_next_addr", imem_addr, 32'h44);
    wait_valid("t2b", 20);
    chk("t2b_iword", iword, 32'hA500_0057);
    drv_psel = 1'b1; drv_bt = 32'h81; drv_ready = 1'b1;
    step();
    drv_psel = 1'b0; drv_ready = 1'b0;
    step();
    chk("t2_flush_valid", {31'd0, iword_valid}, 32'd0);
    chk("t2_flush_iword", iword, 32'h0000_0013);
    chk("t2_flush_addr", imem_addr, 32'h80);

    // Redirect while a fetch is outstanding.
    do_reset();
    mem_lat = 3; mem_ready_on = 1'b0; drv_psel = 1'b1; drv_bt = 32'h10;
    step();
    drv_psel = 1'b0; mem_ready_on = 1'b1;
    step();
    chk("t3_addr", imem_addr, 32'h10);
    drv_psel = 1'b1; drv_bt = 32'h103;
    step();
    drv_psel = 1'b0;
    wait_valid("t3", 20);
    chk("t3_pc", iword_pc, 32'h100);
    chk("t3_iword", iword, 32'hA500_0113);
    chk("t3_acc_n", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) chk("t3_acc1", acc_q[1], 32'h100);

    // Back-to-back redirects during one outstanding fetch.
    do_reset();
    step();
    drv_psel = 1'b1; drv_bt = 32'h500;
    step();
    drv_bt = 32'h600;
    step();
    drv_psel = 1'b0;
    wait_valid("t3b", 20);
    chk("t3b_pc", iword_pc, 32'h600);
    chk("t3b_iword", iword, 32'hA500_0613);

    // Redirect coinciding with the response.
    do_reset();
    mem_lat = 2; mem_ready_on = 1'b0; drv_psel = 1'b1; drv_bt = 32'h20;
    step();
    drv_psel = 1'b0; mem_ready_on = 1'b1;
    step();
    step();
    drv_psel = 1'b1; drv_bt = 32'h200;
    step();
    chk("t4a_resp_same_cycle", {31'd0, imem_resp_valid}, 32'd1);
    drv_psel = 1'b0;
    wait_valid("t4a", 20);
    chk("t4a_pc", iword_pc, 32'h200);
    chk("t4a_iword", iword, 32'hA500_0213);

    // Redirect coinciding with the request handshake.
    do_reset();
    mem_lat = 1; drv_psel = 1'b1; drv_bt = 32'h300;
    step();
    drv_psel = 1'b0;
    wait_valid("t4b", 20);
    chk("t4b_pc", iword_pc, 32'h300);
    chk("t4b_iword", iword, 32'hA500_0313);

    // PC wrap, then reset in the middle of a fetch.
    do_reset();
    mem_ready_on = 1'b0; drv_psel = 1'b1; drv_bt = 32'hFFFF_FFFC;
    step();
    drv_psel = 1'b0; mem_ready_on = 1'b1;
    wait_valid("t5", 20);
    chk("t5_pc", iword_pc, 32'hFFFF_FFFC);
    chk("t5_iword", iword, 32'h5AFF_FFEF);
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0; mem_lat = 4;
    step();
    chk("t5_wrap_req", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_wrap_addr", imem_addr, 32'h0);
    step();
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0; mem_lat = 1;
    step();
    chk("t5_rst_valid", {31'd0, iword_valid}, 32'd0);
    chk("t5_rst_req", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_rst_addr", imem_addr, RESET_PC);
    wait_valid("t5b", 20);
    chk("t5b_pc", iword_pc, 32'h0);

`ifdef IFU_PERF_CNT_EN
    // Event counters: 10 consumes and 3 redirects, then reset.
    do_reset();
    drv_ready = 1'b1; mem_lat = 1; mem_ready_on = 1'b1;
    drv_psel = 1'b1; drv_bt = 32'h1000;
    step();
    chk("perf_start_fetch", fetch_count, 32'd0);
    chk("perf_start_flush", flush_count, 32'd0);
    step();
    step();
    drv_psel = 1'b0;
    n = 0;
    while (del_pc_q.size() < 10 && n < 100) begin
      step();
      n++;
    end
    drv_ready = 1'b0;
    step();
    chk("perf_fetch", fetch_count, 32'd10);
    chk("perf_flush", flush_count, 32'd3);
    do_reset();
    chk("perf_rst_fetch", fetch_count, 32'd0);
    chk("perf_rst_flush", flush_count, 32'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
